// File: rtl/mul_error_profiler_if.sv
// Bus between the multiplier error profiler and its environment: sweep
// control, multiplier operand/product lines and the accumulated statistics.
// The profiler uses the master modport; the multiplier/test side uses slave.
interface mul_error_profiler_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     mul_in1;
  logic [WIDTH-1:0]     mul_in2;
  logic [2*WIDTH-1:0]   mul_out;
  logic                 mul_overflow;
  logic [2*WIDTH:0]     err_count;
  logic [2*WIDTH-1:0]   max_ed;
  logic [4*WIDTH-1:0]   sum_ed;
  logic [2*WIDTH:0]     ovf_count;
  logic [WIDTH-1:0]     first_err_a;
  logic [WIDTH-1:0]     first_err_b;

  modport master (
    input  start, mul_out, mul_overflow,
    output busy, done, mul_in1, mul_in2,
           err_count, max_ed, sum_ed, ovf_count, first_err_a, first_err_b
  );

  modport slave (
    output start, mul_out, mul_overflow,
    input  busy, done, mul_in1, mul_in2,
           err_count, max_ed, sum_ed, ovf_count, first_err_a, first_err_b
  );
endinterface

// File: rtl/mul_error_profiler.sv
// Exhaustive error profiler for a WIDTH x WIDTH unsigned multiplier.
// Walks every operand pair (A outer, B inner), holds each pair LAT+1 cycles,
// samples the product on the last cycle and accumulates mismatch count,
// max/sum of error distance and overflow count.
// Optional macro MUL_PROFILER_FIRST_ERR_EN: record operands of the first
// mismatch of each sweep; otherwise first_err_a/b are tied to 0.
module mul_error_profiler #(
  parameter int WIDTH = 4,
  parameter int LAT   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  mul_error_profiler_if.master bus
);
  localparam int IW = 2 * WIDTH;
  localparam int WW = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [WW-1:0] LAST_W = WW'(LAT);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [IW:0]     err_q, err_d;
  logic [IW-1:0]   max_q, max_d;
  logic [2*IW-1:0] sum_q, sum_d;
  logic [IW:0]     ovf_q, ovf_d;

  logic [WIDTH-1:0] op_a, op_b;
  logic [IW-1:0]    exact, ed;
  logic             start_acc, sample, mismatch;

  assign op_a      = idx_q[IW-1:WIDTH];
  assign op_b      = idx_q[WIDTH-1:0];
  assign exact     = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
  // Distance taken in the direction that cannot wrap.
  assign ed        = (exact >= bus.mul_out) ? (exact - bus.mul_out) : (bus.mul_out - exact);
  assign mismatch  = (ed != '0);
  assign start_acc = (state_q == IDLE) && bus.start;
  assign sample    = (state_q == APPLY) && (wait_q == LAST_W);

  // State, index, wait counter and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      err_q   <= '0;
      max_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  // Sweep sequencing, operand drive and accumulator update.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    err_d       = err_q;
    max_d       = max_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.mul_in1 = '0;
    bus.mul_in2 = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = APPLY;
          idx_d   = '0;
          wait_d  = '0;
          err_d   = '0;
          max_d   = '0;
          sum_d   = '0;
          ovf_d   = '0;
        end
      end
      APPLY: begin
        bus.busy    = 1'b1;
        bus.mul_in1 = op_a;
        bus.mul_in2 = op_b;
        if (wait_q == LAST_W) begin
          if (mismatch)         err_d = err_q + (IW+1)'(1);
          if (ed > max_q)       max_d = ed;
          sum_d = sum_q + {{IW{1'b0}}, ed};
          if (bus.mul_overflow) ovf_d = ovf_q + (IW+1)'(1);
          if (&idx_q) begin
            state_d = DONE;
          end else begin
            idx_d  = idx_q + IW'(1);
            wait_d = '0;
          end
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.err_count = err_q;
  assign bus.max_ed    = max_q;
  assign bus.sum_ed    = sum_q;
  assign bus.ovf_count = ovf_q;

`ifdef MUL_PROFILER_FIRST_ERR_EN
  logic             seen_q;
  logic [WIDTH-1:0] fa_q, fb_q;

  // Latch operands of the first mismatch; cleared by each accepted start.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      seen_q <= 1'b0;
      fa_q   <= '0;
      fb_q   <= '0;
    end else if (sample && mismatch && !seen_q) begin
      seen_q <= 1'b1;
      fa_q   <= op_a;
      fb_q   <= op_b;
    end
  end

  assign bus.first_err_a = fa_q;
  assign bus.first_err_b = fb_q;
`else
  assign bus.first_err_a = '0;
  assign bus.first_err_b = '0;
`endif
endmodule

// File: tb/tb_mul_error_profiler.sv
// Bench for mul_error_profiler: a behavioural multiplier with selectable
// error modes feeds a LAT=0 instance; a 2-stage pipelined exact multiplier
// feeds a LAT=2 instance. Expected sweep results go into queues and are
// checked by monitors when done pulses.
module tb_mul_error_profiler;
  localparam int W = 4;

  typedef struct {
    int cyc; int err; int maxed; int sum; int ovf; int fa; int fb;
  } exp_t;

`ifdef MUL_PROFILER_FIRST_ERR_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   mode;
  int   n_chk = 0, n_pass = 0;
  int   ndone1 = 0, ndone2 = 0;
  int   cnt1 = 0, cnt2 = 0;
  bit   chk_low1 = 0;
  exp_t q1[$], q2[$];

  always #5 clk = ~clk;

  mul_error_profiler_if #(.WIDTH(W)) bus1 ();
  mul_error_profiler_if #(.WIDTH(W)) bus2 ();

  mul_error_profiler #(.WIDTH(W), .LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus1));
  mul_error_profiler #(.WIDTH(W), .LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Behavioural multiplier under profile.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input int m);
    logic [2*W-1:0] p;
    p = {4'd0, a} * {4'd0, b};
    if (m == 1 && a == 4'd3 && b == 4'd3) p = '0;
    if (m == 2) p = p + 8'd1;
    return p;
  endfunction

  assign bus1.mul_out      = model(bus1.mul_in1, bus1.mul_in2, mode);
  assign bus1.mul_overflow = (mode == 3) && (bus1.mul_in1 == 4'hF);

  logic [2*W-1:0] p1, p2;
  always @(posedge clk) begin
    p1 <= {4'd0, bus2.mul_in1} * {4'd0, bus2.mul_in2};
    p2 <= p1;
  end
  assign bus2.mul_out      = p2;
  assign bus2.mul_overflow = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor for the LAT=0 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      cnt1 = 0;
      chk_low1 = 0;
    end else begin
      if (chk_low1) begin
        check("done1_width", bus1.done, 0);
        chk_low1 = 0;
      end
      if (bus1.busy) cnt1++;
      if (bus1.done) begin
        ndone1++;
        chk_low1 = 1;
        if (q1.size() == 0) check("done1_unexpected", 1, 0);
        else begin
          e = q1.pop_front();
          check("sweep1_cycles", cnt1, e.cyc);
          check("err_count", bus1.err_count, e.err);
          check("max_ed", bus1.max_ed, e.maxed);
          check("sum_ed", bus1.sum_ed, e.sum);
          check("ovf_count", bus1.ovf_count, e.ovf);
          check("first_err_a", bus1.first_err_a, e.fa);
          check("first_err_b", bus1.first_err_b, e.fb);
        end
        cnt1 = 0;
      end
    end
  end

  // Monitor for the LAT=2 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst) cnt2 = 0;
    else begin
      if (bus2.busy) cnt2++;
      if (bus2.done) begin
        ndone2++;
        if (q2.size() == 0) check("done2_unexpected", 1, 0);
        else begin
          e = q2.pop_front();
          check("lat2_cycles", cnt2, e.cyc);
          check("lat2_err_count", bus2.err_count, e.err);
          check("lat2_sum_ed", bus2.sum_ed, e.sum);
          check("lat2_max_ed", bus2.max_ed, e.maxed);
        end
        cnt2 = 0;
      end
    end
  end

  task automatic wait_q1();
    int i;
    for (i = 0; i < 2000 && q1.size() != 0; i++) @(negedge clk);
    if (q1.size() != 0) check("q1_timeout", q1.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse1();
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
  endtask

  task automatic sweep(input int m, input exp_t e);
    mode = m;
    q1.push_back(e);
    pulse1();
    wait_q1();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, bus1.busy, 0);
    check({tag, "_done"}, bus1.done, 0);
    check({tag, "_in1"}, bus1.mul_in1, 0);
    check({tag, "_in2"}, bus1.mul_in2, 0);
    check({tag, "_err"}, bus1.err_count, 0);
    check({tag, "_max"}, bus1.max_ed, 0);
    check({tag, "_sum"}, bus1.sum_ed, 0);
    check({tag, "_ovf"}, bus1.ovf_count, 0);
    check({tag, "_fa"}, bus1.first_err_a, 0);
    check({tag, "_fb"}, bus1.first_err_b, 0);
  endtask

  initial begin
    rst = 1'b1;
    mode = 0;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Exact model, single error at (3,3), off-by-one everywhere.
    sweep(0, '{256, 0, 0, 0, 0, 0, 0});
    sweep(1, '{256, 1, 9, 9, 0, FE ? 3 : 0, FE ? 3 : 0});
    sweep(2, '{256, 256, 1, 256, 0, 0, 0});

    // Results held while idle; operands parked at 0.
    repeat (5) @(negedge clk);
    check("idle_hold_err", bus1.err_count, 256);
    check("idle_hold_sum", bus1.sum_ed, 256);
    check("idle_in1", bus1.mul_in1, 0);
    check("idle_busy", bus1.busy, 0);

    // Reset in the middle of an erroring sweep, then a clean sweep.
    mode = 2;
    pulse1();
    repeat (99) @(negedge clk);
    check("pre_rst_busy", bus1.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    sweep(0, '{256, 0, 0, 0, 0, 0, 0});

    // Start re-pulsed mid-sweep is ignored; overflow counted for in1=15.
    mode = 3;
    q1.push_back('{256, 0, 0, 0, 16, 0, 0});
    pulse1();
    repeat (49) @(negedge clk);
    pulse1();
    wait_q1();

    // Pipelined multiplier, operands held three cycles each.
    q2.push_back('{768, 0, 0, 0, 0, 0, 0});
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    for (int i = 0; i < 2000 && q2.size() != 0; i++) @(negedge clk);
    if (q2.size() != 0) check("q2_timeout", q2.size(), 0);
    repeat (2) @(negedge clk);

    check("done1_total", ndone1, 5);
    check("done2_total", ndone2, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
